// File: rtl/output_switch_arbiter.sv
// Per-output-port round-robin switch allocator that locks one input onto the port for a whole packet.
// Optional idle-lock watchdog is compiled in when ARB_WATCHDOG_EN is defined.
module output_switch_arbiter #(
    parameter int NUM_PORTS      = 5,
    parameter int IDX_W          = $clog2(NUM_PORTS),
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic                 i_out_ready,
    input  logic                 i_xfer,
    input  logic                 i_xfer_tail,
    output logic [NUM_PORTS-1:0] o_grant,
    output logic [IDX_W-1:0]     o_grant_idx,
    output logic                 o_busy,
    output logic                 o_abort,
    output logic                 o_timeout
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] winner;
    logic             winner_found;
    logic [IDX_W-1:0] ptr_next;
    logic             tail_done;
    logic             lost_req;
    logic             wd_fire;
    logic             release_lock;

    // Port index (base + off) modulo NUM_PORTS; both operands are already below NUM_PORTS.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                  input int unsigned      off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= 32'(NUM_PORTS)) begin
            sum = sum - 32'(NUM_PORTS);
        end
        return IDX_W'(sum);
    endfunction

    // Scan from the farthest offset down so the requester closest to ptr is written last and wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        winner       = '0;
        winner_found = 1'b0;
        for (int off = NUM_PORTS - 1; off >= 0; off--) begin
            if (i_req[wrap_add(ptr, off)]) begin
                winner       = wrap_add(ptr, off);
                winner_found = 1'b1;
            end
        end
    end

    assign ptr_next     = wrap_add(o_grant_idx, 1);
    assign tail_done    = i_xfer && i_xfer_tail;
    assign lost_req     = !i_req[o_grant_idx];
    assign release_lock = (state == LOCKED) && (tail_done || lost_req || wd_fire);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            ptr         <= '0;
            o_grant     <= '0;
            o_grant_idx <= '0;
            o_busy      <= 1'b0;
            o_abort     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            o_abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (winner_found && i_out_ready) begin
                        state       <= LOCKED;
                        o_grant     <= NUM_PORTS'(1) << winner;
                        o_grant_idx <= winner;
                        o_busy      <= 1'b1;
                    end
                end
                LOCKED: begin
                    // A tail in the same cycle as the request drop is a clean finish, not an abort.
                    if (release_lock) begin
                        state       <= IDLE;
                        ptr         <= ptr_next;
                        o_grant     <= '0;
                        o_grant_idx <= '0;
                        o_busy      <= 1'b0;
                        o_abort     <= lost_req && !tail_done;
                    end
                end
            endcase
        end
    end

`ifdef ARB_WATCHDOG_EN
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [CNT_W-1:0] wd_cnt;

    assign wd_fire = (state == LOCKED) && !i_xfer && (wd_cnt == CNT_LAST);

    // Counts consecutive locked cycles without a flit; held at zero whenever the port is idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt    <= '0;
            o_timeout <= 1'b0;
        end else begin
            o_timeout <= wd_fire && !lost_req;
            if (state != LOCKED || release_lock || i_xfer) begin
                wd_cnt <= '0;
            end else if (wd_cnt != CNT_MAX) begin
                wd_cnt <= wd_cnt + CNT_W'(1);
            end
        end
    end
`else
    assign wd_fire   = 1'b0;
    assign o_timeout = 1'b0;
`endif

    cfg_timeout_valid: assert property (@(posedge clk) TIMEOUT_CYCLES >= 2);

    grant_onehot: assert property (@(posedge clk) disable iff (!reset_n)
        $onehot0(o_grant));

    busy_tracks_grant: assert property (@(posedge clk) disable iff (!reset_n)
        o_busy == (o_grant != '0));

    idx_tracks_grant: assert property (@(posedge clk) disable iff (!reset_n)
        o_busy |-> o_grant[o_grant_idx]);

    abort_only_on_release: assert property (@(posedge clk) disable iff (!reset_n)
        o_abort |-> !o_busy);

endmodule

// File: tb/tb_output_switch_arbiter.sv
// Self-checking bench for output_switch_arbiter: vector table, hand-written corner sequences and
// randomized traffic against a behavioural round-robin model.
module tb_output_switch_arbiter;

    localparam int N = 5;
    localparam int T = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [N-1:0] req = '0;
    logic         ready = 1'b0;
    logic         xfer = 1'b0;
    logic         tail = 1'b0;
    logic [N-1:0] grant;
    logic [2:0]   gidx;
    logic         busy;
    logic         abort;
    logic         tmo;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit model_on = 1'b0;
    bit m_locked;
    int m_win;
    int m_ptr;
    int m_idle;
    bit m_abort;
    bit m_to;

    typedef struct {
        logic [N-1:0] req;
        logic         ready;
        logic         xfer;
        logic         tail;
        logic [N-1:0] grant;
        int           idx;
        logic         busy;
        logic         abort;
    } vec_t;

    vec_t vecs[14];

    output_switch_arbiter #(
        .NUM_PORTS     (N),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_req      (req),
        .i_out_ready(ready),
        .i_xfer     (xfer),
        .i_xfer_tail(tail),
        .o_grant    (grant),
        .o_grant_idx(gidx),
        .o_busy     (busy),
        .o_abort    (abort),
        .o_timeout  (tmo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_outs(input string name, input logic [N-1:0] g, input int idx,
                               input logic b, input logic a, input logic t);
        check({name, ".grant"}, 32'(grant), 32'(g));
        check({name, ".idx"}, 32'(gidx), 32'(idx));
        check({name, ".busy"}, 32'(busy), 32'(b));
        check({name, ".abort"}, 32'(abort), 32'(a));
        check({name, ".timeout"}, 32'(tmo), 32'(t));
    endtask

    function automatic void model_reset();
        m_locked = 1'b0;
        m_win    = 0;
        m_ptr    = 0;
        m_idle   = 0;
        m_abort  = 1'b0;
        m_to     = 1'b0;
    endfunction

    function automatic void model_release();
        m_locked = 1'b0;
        m_ptr    = (m_win + 1) % N;
    endfunction

    // One clock of the allocation rules, evaluated on the inputs present at the edge.
    function automatic void model_step();
        bit found;
        m_abort = 1'b0;
        m_to    = 1'b0;
        if (!m_locked) begin
            found = 1'b0;
            if (ready && req != '0) begin
                for (int k = 0; k < N; k++) begin
                    if (!found && req[(m_ptr + k) % N]) begin
                        found    = 1'b1;
                        m_win    = (m_ptr + k) % N;
                        m_locked = 1'b1;
                        m_idle   = 0;
                    end
                end
            end
        end else if (xfer && tail) begin
            model_release();
        end else if (!req[m_win]) begin
            model_release();
            m_abort = 1'b1;
        end
`ifdef ARB_WATCHDOG_EN
        else if (!xfer && m_idle == T - 1) begin
            model_release();
            m_to = 1'b1;
        end
`endif
        else if (xfer) begin
            m_idle = 0;
        end else begin
            m_idle = m_idle + 1;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        if (model_on) model_step();
        #1;
        if (model_on) begin
            expect_outs("rnd", m_locked ? (N'(1) << m_win) : '0, m_locked ? m_win : 0,
                        m_locked, m_abort, m_to);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req     = '0;
        ready   = 1'b0;
        xfer    = 1'b0;
        tail    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        expect_outs("reset", '0, 0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        int xfer_bias;
        logic [N-1:0] r;

        //            req       rdy   xfer  tail  grant     idx busy abort
        vecs[0]  = '{5'b00110, 1'b1, 1'b0, 1'b0, 5'b00010, 1, 1'b1, 1'b0};
        vecs[1]  = '{5'b00111, 1'b1, 1'b1, 1'b0, 5'b00010, 1, 1'b1, 1'b0};
        vecs[2]  = '{5'b00111, 1'b1, 1'b1, 1'b0, 5'b00010, 1, 1'b1, 1'b0};
        vecs[3]  = '{5'b00111, 1'b1, 1'b1, 1'b0, 5'b00010, 1, 1'b1, 1'b0};
        vecs[4]  = '{5'b00111, 1'b1, 1'b1, 1'b1, 5'b00000, 0, 1'b0, 1'b0};
        vecs[5]  = '{5'b00111, 1'b1, 1'b0, 1'b0, 5'b00100, 2, 1'b1, 1'b0};
        vecs[6]  = '{5'b00011, 1'b1, 1'b0, 1'b0, 5'b00000, 0, 1'b0, 1'b1};
        vecs[7]  = '{5'b00011, 1'b0, 1'b0, 1'b0, 5'b00000, 0, 1'b0, 1'b0};
        vecs[8]  = '{5'b00011, 1'b1, 1'b0, 1'b0, 5'b00001, 0, 1'b1, 1'b0};
        vecs[9]  = '{5'b00010, 1'b1, 1'b1, 1'b1, 5'b00000, 0, 1'b0, 1'b0};
        vecs[10] = '{5'b00010, 1'b1, 1'b1, 1'b1, 5'b00010, 1, 1'b1, 1'b0};
        vecs[11] = '{5'b00010, 1'b1, 1'b0, 1'b1, 5'b00010, 1, 1'b1, 1'b0};
        vecs[12] = '{5'b00010, 1'b0, 1'b0, 1'b0, 5'b00010, 1, 1'b1, 1'b0};
        vecs[13] = '{5'b00010, 1'b0, 1'b1, 1'b1, 5'b00000, 0, 1'b0, 1'b0};

        do_reset();
        for (int i = 0; i < 14; i++) begin
            req   = vecs[i].req;
            ready = vecs[i].ready;
            xfer  = vecs[i].xfer;
            tail  = vecs[i].tail;
            tick();
            expect_outs($sformatf("vec%0d", i), vecs[i].grant, vecs[i].idx,
                        vecs[i].busy, vecs[i].abort, 1'b0);
        end

        // Fairness: five continuous requesters, single-flit packets
        do_reset();
        req   = 5'b11111;
        ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            expect_outs($sformatf("fair_grant%0d", k), N'(1) << (k % N), k % N, 1'b1, 1'b0, 1'b0);
            xfer = 1'b1;
            tail = 1'b1;
            tick();
            expect_outs($sformatf("fair_gap%0d", k), '0, 0, 1'b0, 1'b0, 1'b0);
            xfer = 1'b0;
            tail = 1'b0;
        end

        // Abort on port 3, then wrap-around from ptr=4 to port 0
        do_reset();
        req   = 5'b01000;
        ready = 1'b1;
        tick();
        expect_outs("abort_lock", 5'b01000, 3, 1'b1, 1'b0, 1'b0);
        req = 5'b10001;
        tick();
        expect_outs("abort_pulse", '0, 0, 1'b0, 1'b1, 1'b0);
        tick();
        expect_outs("wrap_grant4", 5'b10000, 4, 1'b1, 1'b0, 1'b0);
        xfer = 1'b1;
        tail = 1'b1;
        tick();
        expect_outs("wrap_release", '0, 0, 1'b0, 1'b0, 1'b0);
        xfer = 1'b0;
        tail = 1'b0;
        tick();
        expect_outs("wrap_grant0", 5'b00001, 0, 1'b1, 1'b0, 1'b0);
        req  = 5'b00000;
        xfer = 1'b1;
        tail = 1'b1;
        tick();
        expect_outs("tail_with_drop", '0, 0, 1'b0, 1'b0, 1'b0);
        xfer = 1'b0;
        tail = 1'b0;

        // Output not ready: no grant however many requests
        do_reset();
        req   = 5'b11111;
        ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            expect_outs($sformatf("not_ready%0d", k), '0, 0, 1'b0, 1'b0, 1'b0);
        end

        // Reset mid-lock clears outputs asynchronously and returns ptr to 0
        do_reset();
        req   = 5'b00010;
        ready = 1'b1;
        tick();
        xfer = 1'b1;
        tail = 1'b1;
        tick();
        xfer = 1'b0;
        tail = 1'b0;
        req  = 5'b01000;
        tick();
        expect_outs("pre_reset_lock", 5'b01000, 3, 1'b1, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        expect_outs("async_reset", '0, 0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        req     = 5'b11111;
        tick();
        expect_outs("post_reset_ptr", 5'b00001, 0, 1'b1, 1'b0, 1'b0);

`ifdef ARB_WATCHDOG_EN
        // Watchdog: lock with no flit movement releases after T cycles
        do_reset();
        req   = 5'b00001;
        ready = 1'b1;
        tick();
        expect_outs("wd_lock", 5'b00001, 0, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k < T; k++) begin
            tick();
            expect_outs($sformatf("wd_hold%0d", k), 5'b00001, 0, 1'b1, 1'b0, 1'b0);
        end
        tick();
        expect_outs("wd_fire", '0, 0, 1'b0, 1'b0, 1'b1);
        tick();
        expect_outs("wd_regrant", 5'b00001, 0, 1'b1, 1'b0, 1'b0);
`endif

        // Randomized traffic against the model
        do_reset();
        model_reset();
        model_on  = 1'b1;
        xfer_bias = 4;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) xfer_bias = int'($urandom_range(0, 5));
            r = N'($urandom_range(0, 31));
            if (m_locked && $urandom_range(0, 19) != 0) r[m_win] = 1'b1;
            req   = r;
            ready = ($urandom_range(0, 3) != 0);
            xfer  = (int'($urandom_range(0, 7)) < xfer_bias);
            tail  = ($urandom_range(0, 3) == 0);
            tick();
        end
        model_on = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/output_switch_arbiter.md
Name:
output_switch_arbiter

Overview:
Per-output-port switch allocator for the router crossbar. Arbitrates among input units requesting the same output port with a round-robin policy. Locks the winning input onto the port for a whole packet, head to tail, and releases the port on the tail-flit transfer. One instance sits in front of each output unit and drives that unit's switch-request input.

Parameters:
NUM_PORTS, 5, number of input ports competing for this output (N, E, S, W, Local).
IDX_W, $clog2(NUM_PORTS), width of the encoded grant index.
TIMEOUT_CYCLES, 256, idle-lock limit used only when ARB_WATCHDOG_EN is defined.

Ports:
clk  input  1  clock.
reset_n  input  1  asynchronous, active-low reset.
i_req  input  NUM_PORTS  bit p set: input p holds a head flit routed to this output.
i_out_ready  input  1  the output unit is free and able to accept a new packet.
i_xfer  input  1  one flit of the granted packet crossed the switch this cycle.
i_xfer_tail  input  1  the flit on i_xfer is a tail flit; qualified by i_xfer.
o_grant  output  NUM_PORTS  one-hot grant to the winning input; all zeros when idle.
o_grant_idx  output  IDX_W  encoded winner; valid while o_busy is high.
o_busy  output  1  port locked to a packet.
o_abort  output  1  one-cycle pulse: lock released because the winner dropped its request before the tail.
o_timeout  output  1  one-cycle pulse when the watchdog fires; tied 0 when the feature is compiled out.

Behaviour:
- Reset (async, active-low): state IDLE, o_grant=0, o_grant_idx=0, o_busy=0, o_abort=0, o_timeout=0, priority pointer ptr=0, watchdog counter=0. All outputs are registered.
- States: IDLE, LOCKED.
- IDLE, when |i_req && i_out_ready:
  - Winner is the first p with i_req[p]=1, searching p = ptr, ptr+1, ... modulo NUM_PORTS.
  - Next cycle: o_grant = one-hot(winner), o_grant_idx = winner, o_busy = 1, state LOCKED.
  - Latency from request to grant is one cycle.
- IDLE, when no requests or i_out_ready=0: remain in IDLE; outputs stay 0.
- LOCKED: o_grant and o_grant_idx stay stable and ignore all other requests.
- LOCKED, when i_xfer && i_xfer_tail:
  - Next cycle: o_grant=0, o_busy=0, ptr = (winner+1) wrapping NUM_PORTS-1 to 0, state IDLE.
  - There is one mandatory idle cycle before the next arbitration, so back-to-back packets see a 2-cycle gap from tail to new grant.
- LOCKED, when i_req[winner] falls without a tail transfer that cycle:
  - Release exactly as on a tail; ptr advances; o_abort pulses high for one cycle, aligned with o_grant going to 0.
- LOCKED, tail transfer in the same cycle that i_req[winner] falls: treat as a normal tail; no o_abort.
- i_xfer while IDLE: ignored.
- i_xfer_tail without i_xfer: ignored.
- i_out_ready is sampled only in IDLE; a change while LOCKED has no effect.
- Single-flit packet (head = tail): handled as a tail, so the lock lasts one cycle.
- Requests from other ports during LOCKED are neither lost nor latched; they are re-evaluated combinationally in the first IDLE cycle.
- Reset asserted mid-packet: immediate return to reset values; ptr returns to 0.

Optional Feature:
ARB_WATCHDOG_EN.
- Defined:
  - A counter clears on entering LOCKED and on every i_xfer, and increments on each LOCKED cycle with no i_xfer.
  - When it reaches TIMEOUT_CYCLES-1 with no i_xfer, the next cycle forces release: same effect as a tail, plus a one-cycle o_timeout pulse and ptr advance.
  - Counter width is $clog2(TIMEOUT_CYCLES)+1 and saturates; it never wraps.
- Not defined: no counter logic; o_timeout is constant 0; a lock persists until tail or abort.

Test Plan:
- Reset, ptr=0, i_req=5'b00110, i_out_ready=1 -> next cycle o_grant=5'b00010, o_grant_idx=1, o_busy=1.
- Port 1 locked, i_req=5'b00111 held; drive 3 body i_xfer, then a tail xfer -> o_grant stays 5'b00010 throughout; 1 cycle after tail o_grant=0; 1 cycle later o_grant=5'b00100 (ptr=2).
- Fairness: all 5 ports request continuously, each packet 1 flit -> grants rotate 0,1,2,3,4,0 with a 2-cycle period per grant; no port repeats before all others are served.
- Wrap-around: ptr=4, i_req=5'b10001 -> grant port 4; after its tail, ptr=0 and port 0 is granted next.
- Abort: port 3 locked, drop i_req[3] with no tail -> next cycle o_grant=0, o_abort=1 for exactly 1 cycle, ptr=4; a same-cycle tail plus request drop -> o_abort=0.
- i_out_ready=0 with i_req=5'b11111 for 10 cycles -> o_grant=0 throughout. With ARB_WATCHDOG_EN and TIMEOUT_CYCLES=8: lock with no i_xfer -> o_timeout pulses 8 cycles after the lock and the port releases. Assert reset_n=0 mid-lock -> all outputs 0 asynchronously.
